// File: rtl/utime_timer.sv
// Machine timer: APB view of the board microsecond counter, a 64-bit compare
// register and a two-stage registered interrupt (mtime/mtimecmp style).
module utime_timer #(
  parameter int          ADDR_WIDTH = 5,
  parameter logic [63:0] CMP_RESET  = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic                  clk_cpu,
  input  logic                  nreset,
  input  logic [63:0]           utime,
  input  logic [ADDR_WIDTH-1:0] apb_PADDR,
  input  logic                  apb_PSEL,
  input  logic                  apb_PENABLE,
  output logic                  apb_PREADY,
  input  logic                  apb_PWRITE,
  input  logic [31:0]           apb_PWDATA,
  output logic [31:0]           apb_PRDATA,
  output logic                  timer_irq
);

  localparam logic [2:0] A_TIME_LO = 3'd0;
  localparam logic [2:0] A_TIME_HI = 3'd1;
  localparam logic [2:0] A_CMP_LO  = 3'd2;
  localparam logic [2:0] A_CMP_HI  = 3'd3;
  localparam logic [2:0] A_CMP_ADD = 3'd4;
  localparam logic [2:0] A_CTRL    = 3'd5;

  logic [63:0] cmp_reg;
  logic [31:0] time_hi_shadow_reg;
  logic [31:0] prdata_reg;
  logic        pready_reg;
  logic        ie_reg;
  logic        ge_reg;
  logic        irq_reg;

  logic [2:0]  addr_idx;
  logic        setup_phase;
  logic        wr_commit;
  logic [31:0] rd_word [8];
  logic        unused_addr_bits;

  assign addr_idx    = apb_PADDR[4:2];
  assign setup_phase = apb_PSEL & ~apb_PENABLE;
  // Only the first access cycle (the one flagged by pready_reg) commits a write.
  assign wr_commit   = apb_PSEL & apb_PENABLE & apb_PWRITE & pready_reg;

  assign unused_addr_bits = &{1'b0, apb_PADDR};

  assign rd_word[A_TIME_LO] = utime[31:0];
  assign rd_word[A_TIME_HI] = time_hi_shadow_reg;
  assign rd_word[A_CMP_LO]  = cmp_reg[31:0];
  assign rd_word[A_CMP_HI]  = cmp_reg[63:32];
  assign rd_word[A_CMP_ADD] = 32'd0;
  assign rd_word[A_CTRL]    = {30'd0, ge_reg, ie_reg};

  genvar gi;
  generate
    for (gi = 6; gi < 8; gi++) begin : g_reserved
      assign rd_word[gi] = 32'd0;
    end
  endgenerate

  always_ff @(posedge clk_cpu or negedge nreset) begin
    if (!nreset) begin
      cmp_reg            <= CMP_RESET;
      time_hi_shadow_reg <= 32'd0;
      prdata_reg         <= 32'd0;
      pready_reg         <= 1'b0;
      ie_reg             <= 1'b0;
      ge_reg             <= 1'b0;
      irq_reg            <= 1'b0;
    end else begin
      pready_reg <= setup_phase;

      // Reading TIME_LO freezes the upper word so a later TIME_HI read matches it.
      if (setup_phase && !apb_PWRITE) begin
        prdata_reg <= rd_word[addr_idx];
        if (addr_idx == A_TIME_LO) begin
          time_hi_shadow_reg <= utime[63:32];
        end
      end

      if (wr_commit) begin
        case (addr_idx)
          A_CMP_LO:  cmp_reg[31:0]  <= apb_PWDATA;
          A_CMP_HI:  cmp_reg[63:32] <= apb_PWDATA;
          A_CMP_ADD: cmp_reg        <= utime + {32'd0, apb_PWDATA};
          A_CTRL:    ie_reg         <= apb_PWDATA[0];
          default:   ;
        endcase
      end

      ge_reg  <= (utime >= cmp_reg);
      irq_reg <= ge_reg & ie_reg;
    end
  end

  assign apb_PREADY = pready_reg & apb_PSEL;
  assign apb_PRDATA = prdata_reg;
  assign timer_irq  = irq_reg;

endmodule

// File: tb/tb_utime_timer.sv
// Directed bench for utime_timer: APB register access, atomic time reads,
// compare/interrupt timing, CMP_ADD carry and wrap, and reset mid-transfer.
module tb_utime_timer;

  logic        clk_cpu;
  logic        nreset;
  logic [63:0] utime;
  logic [4:0]  apb_PADDR;
  logic        apb_PSEL;
  logic        apb_PENABLE;
  logic        apb_PREADY;
  logic        apb_PWRITE;
  logic [31:0] apb_PWDATA;
  logic [31:0] apb_PRDATA;
  logic        timer_irq;

  int errors = 0;
  int checks = 0;

  utime_timer #(
    .ADDR_WIDTH(5),
    .CMP_RESET (64'hFFFF_FFFF_FFFF_FFFF)
  ) dut (
    .clk_cpu    (clk_cpu),
    .nreset     (nreset),
    .utime      (utime),
    .apb_PADDR  (apb_PADDR),
    .apb_PSEL   (apb_PSEL),
    .apb_PENABLE(apb_PENABLE),
    .apb_PREADY (apb_PREADY),
    .apb_PWRITE (apb_PWRITE),
    .apb_PWDATA (apb_PWDATA),
    .apb_PRDATA (apb_PRDATA),
    .timer_irq  (timer_irq)
  );

  initial clk_cpu = 1'b0;
  always #5 clk_cpu = ~clk_cpu;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Each transfer: setup, one access cycle, then idle; PREADY checked in all three.
  task automatic apb_write(input logic [2:0] idx, input logic [31:0] data, input string tag);
    @(negedge clk_cpu);
    apb_PSEL = 1'b1; apb_PENABLE = 1'b0; apb_PWRITE = 1'b1;
    apb_PADDR = {idx, 2'b00}; apb_PWDATA = data;
    #1 check({tag, " pready setup"}, {63'd0, apb_PREADY}, 64'd0);
    @(negedge clk_cpu);
    apb_PENABLE = 1'b1;
    #1 check({tag, " pready access"}, {63'd0, apb_PREADY}, 64'd1);
    @(negedge clk_cpu);
    apb_PSEL = 1'b0; apb_PENABLE = 1'b0; apb_PWRITE = 1'b0;
    #1 check({tag, " pready idle"}, {63'd0, apb_PREADY}, 64'd0);
  endtask

  task automatic apb_read(input logic [2:0] idx, input logic [31:0] exp, input string tag);
    @(negedge clk_cpu);
    apb_PSEL = 1'b1; apb_PENABLE = 1'b0; apb_PWRITE = 1'b0;
    apb_PADDR = {idx, 2'b00};
    #1 check({tag, " pready setup"}, {63'd0, apb_PREADY}, 64'd0);
    @(negedge clk_cpu);
    apb_PENABLE = 1'b1;
    #1 check({tag, " pready access"}, {63'd0, apb_PREADY}, 64'd1);
    check({tag, " prdata"}, {32'd0, apb_PRDATA}, {32'd0, exp});
    @(negedge clk_cpu);
    apb_PSEL = 1'b0; apb_PENABLE = 1'b0;
    #1 check({tag, " pready idle"}, {63'd0, apb_PREADY}, 64'd0);
  endtask

  initial begin
    nreset = 1'b0; utime = 64'd0;
    apb_PADDR = '0; apb_PSEL = 1'b0; apb_PENABLE = 1'b0;
    apb_PWRITE = 1'b0; apb_PWDATA = '0;

    // Reset state
    repeat (3) @(negedge clk_cpu);
    check("rst irq", {63'd0, timer_irq}, 64'd0);
    check("rst pready", {63'd0, apb_PREADY}, 64'd0);
    check("rst prdata", {32'd0, apb_PRDATA}, 64'd0);
    nreset = 1'b1;
    apb_read(3'd5, 32'h0000_0000, "rst CTRL");
    apb_read(3'd2, 32'hFFFF_FFFF, "rst CMP_LO");
    apb_read(3'd3, 32'hFFFF_FFFF, "rst CMP_HI");
    apb_read(3'd6, 32'h0000_0000, "reserved 6");
    check("rst irq after", {63'd0, timer_irq}, 64'd0);

    // Atomic 64-bit read across a carry into the upper word
    utime = 64'h0000_0001_FFFF_FFFE;
    apb_read(3'd0, 32'hFFFF_FFFE, "TIME_LO");
    utime = 64'h0000_0002_0000_0005;
    apb_read(3'd1, 32'h0000_0001, "TIME_HI shadow");

    // Compare + IE: irq rises two edges after utime reaches 1005
    utime = 64'd1000;
    apb_write(3'd3, 32'd0, "w CMP_HI");
    apb_write(3'd2, 32'd1005, "w CMP_LO");
    apb_write(3'd5, 32'd1, "w CTRL=1");
    check("irq before step", {63'd0, timer_irq}, 64'd0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk_cpu);
      #1 check($sformatf("step irq k=%0d", k), {63'd0, timer_irq}, {63'd0, (k >= 6)});
      utime = 64'd1001 + 64'(k);
    end
    apb_read(3'd5, 32'h0000_0003, "CTRL pending");
    apb_write(3'd5, 32'd0, "w CTRL=0");
    check("irq at access+0", {63'd0, timer_irq}, 64'd1);
    @(negedge clk_cpu);
    #1 check("irq after IE clear", {63'd0, timer_irq}, 64'd0);

    // CMP_ADD carries into the upper word
    utime = 64'h0000_0000_FFFF_FFF0;
    apb_write(3'd4, 32'h20, "w CMP_ADD carry");
    apb_read(3'd3, 32'h0000_0001, "CMP_ADD HI");
    apb_read(3'd2, 32'h0000_0010, "CMP_ADD LO");
    apb_read(3'd4, 32'h0000_0000, "CMP_ADD reads 0");

    // CMP_ADD wraps modulo 2^64
    apb_write(3'd3, 32'hFFFF_FFFF, "w CMP_HI max");
    apb_write(3'd2, 32'hFFFF_FFFF, "w CMP_LO max");
    apb_write(3'd5, 32'd1, "w CTRL=1 again");
    utime = 64'hFFFF_FFFF_FFFF_FFF0;
    repeat (2) @(negedge clk_cpu);
    #1 check("irq below max cmp", {63'd0, timer_irq}, 64'd0);
    apb_write(3'd4, 32'h20, "w CMP_ADD wrap");
    check("wrap irq +0", {63'd0, timer_irq}, 64'd0);
    repeat (2) @(negedge clk_cpu);
    #1 check("wrap irq +2", {63'd0, timer_irq}, 64'd1);
    apb_read(3'd2, 32'h0000_0010, "wrap CMP_LO");
    apb_read(3'd3, 32'h0000_0000, "wrap CMP_HI");

    // utime itself wraps below cmp, then climbs back above it
    utime = 64'd5;
    repeat (2) @(negedge clk_cpu);
    #1 check("irq after utime wrap", {63'd0, timer_irq}, 64'd0);
    utime = 64'h20;
    repeat (2) @(negedge clk_cpu);
    #1 check("irq before reset", {63'd0, timer_irq}, 64'd1);

    // Async reset between setup and access edges of a CMP_LO write
    @(negedge clk_cpu);
    apb_PSEL = 1'b1; apb_PENABLE = 1'b0; apb_PWRITE = 1'b1;
    apb_PADDR = {3'd2, 2'b00}; apb_PWDATA = 32'd5;
    @(negedge clk_cpu);
    apb_PENABLE = 1'b1;
    #2 nreset = 1'b0;
    #1 check("irq at async reset", {63'd0, timer_irq}, 64'd0);
    check("pready at async reset", {63'd0, apb_PREADY}, 64'd0);
    @(negedge clk_cpu);
    apb_PSEL = 1'b0; apb_PENABLE = 1'b0; apb_PWRITE = 1'b0;
    @(negedge clk_cpu);
    nreset = 1'b1;
    apb_read(3'd2, 32'hFFFF_FFFF, "post-rst CMP_LO");
    apb_read(3'd3, 32'hFFFF_FFFF, "post-rst CMP_HI");
    apb_read(3'd5, 32'h0000_0000, "post-rst CTRL");
    check("post-rst irq", {63'd0, timer_irq}, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
